// File: rtl/digit8_count_ctrl.sv
// Start/pause/clear controller for an 8-digit up/down counter driven by a tick prescaler.
// Optional lap/display-hold feature is enabled by defining DIGIT8_LAP_HOLD_EN.
module digit8_count_ctrl #(
  parameter logic [22:0] TICK_MAX = 23'd4_999_999,
  parameter logic [26:0] NUM_MAX  = 27'd9999_9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        dir,
  input  logic        lap,
  output logic [26:0] count,
  output logic [26:0] num,
  output logic [1:0]  state,
  output logic        running,
  output logic        wrap,
  output logic        hold
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    BAD   = 2'b11
  } state_t;

  state_t      state_q;
  logic [22:0] presc;
  logic        tick;

  // Next count value with wrap-around at both ends of 0..NUM_MAX.
  function automatic logic [26:0] count_step(input logic [26:0] c, input logic down);
    if (down)
      count_step = (c == 27'd0) ? NUM_MAX : c - 27'd1;
    else
      count_step = (c == NUM_MAX) ? 27'd0 : c + 27'd1;
  endfunction

  function automatic logic is_wrap(input logic [26:0] c, input logic down);
    is_wrap = down ? (c == 27'd0) : (c == NUM_MAX);
  endfunction

  assign tick    = (state_q == RUN) && (presc == TICK_MAX);
  assign state   = state_q;
  assign running = (state_q == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      presc   <= 23'd0;
      count   <= 27'd0;
      wrap    <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clear) begin
        state_q <= IDLE;
        presc   <= 23'd0;
        count   <= 27'd0;
      end else begin
        case (state_q)
          IDLE: begin
            presc <= 23'd0;
            count <= 27'd0;
            if (start_stop) state_q <= RUN;
          end
          RUN: begin
            // A pause request freezes the prescaler where it stands unless this is the tick.
            if (tick) begin
              presc <= 23'd0;
              count <= count_step(count, dir);
              wrap  <= is_wrap(count, dir);
            end else if (!start_stop) begin
              presc <= presc + 23'd1;
            end
            if (start_stop) state_q <= PAUSE;
          end
          PAUSE: begin
            if (start_stop) state_q <= RUN;
          end
          default: begin
            state_q <= IDLE;
            presc   <= 23'd0;
            count   <= 27'd0;
          end
        endcase
      end
    end
  end

`ifdef DIGIT8_LAP_HOLD_EN
  logic [26:0] num_cap;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hold <= 1'b0;
    end else if (lap && (state_q == RUN || state_q == PAUSE)) begin
      if (!hold) begin
        num_cap <= count;
        hold    <= 1'b1;
      end else begin
        hold <= 1'b0;
      end
    end
  end

  assign num = hold ? num_cap : count;
`else
  assign hold = 1'b0;
  assign num  = count;
`endif

endmodule

// File: tb/tb_digit8_count_ctrl.sv
// Directed bench for digit8_count_ctrl with TICK_MAX = 3 and NUM_MAX = 9.
module tb_digit8_count_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_stop = 1'b0;
  logic        clear = 1'b0;
  logic        dir = 1'b0;
  logic        lap = 1'b0;
  logic [26:0] count;
  logic [26:0] num;
  logic [1:0]  state;
  logic        running;
  logic        wrap;
  logic        hold;

  int checks = 0;
  int errors = 0;

  digit8_count_ctrl #(
    .TICK_MAX(23'd3),
    .NUM_MAX (27'd9)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_stop(start_stop),
    .clear     (clear),
    .dir       (dir),
    .lap       (lap),
    .count     (count),
    .num       (num),
    .state     (state),
    .running   (running),
    .wrap      (wrap),
    .hold      (hold)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (state !== 2'b00 || count !== 27'd0 || num !== 27'd0 || wrap !== 1'b0 ||
        hold !== 1'b0 || running !== 1'b0) begin
      errors++;
      $display("FAIL reset: state=%b count=%0d num=%0d wrap=%b hold=%b running=%b expected 00/0/0/0/0/0",
               state, count, num, wrap, hold, running);
    end
    rst = 1'b0;
  endtask

  task automatic test_count_up();
    logic saw_wrap;
    saw_wrap = 1'b0;
    dir = 1'b0;
    pulse_ss();
    checks++;
    if (state !== 2'b01 || running !== 1'b1) begin
      errors++;
      $display("FAIL start_run: state=%b running=%b expected 01/1", state, running);
    end
    repeat (3) begin step(); saw_wrap |= wrap; end
    checks++;
    if (count !== 27'd0) begin
      errors++;
      $display("FAIL up_before_tick: count=%0d expected 0", count);
    end
    step();
    saw_wrap |= wrap;
    checks++;
    if (count !== 27'd1) begin
      errors++;
      $display("FAIL up_count1: count=%0d expected 1", count);
    end
    repeat (4) begin step(); saw_wrap |= wrap; end
    checks++;
    if (count !== 27'd2) begin
      errors++;
      $display("FAIL up_count2: count=%0d expected 2", count);
    end
    checks++;
    if (saw_wrap !== 1'b0) begin
      errors++;
      $display("FAIL up_no_wrap: wrap seen=%b expected 0", saw_wrap);
    end
  endtask

  task automatic test_wrap();
    do_clear();
    dir = 1'b1;
    pulse_ss();
    repeat (3) step();
    checks++;
    if (count !== 27'd0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL down_pre: count=%0d wrap=%b expected 0/0", count, wrap);
    end
    step();
    checks++;
    if (count !== 27'd9 || wrap !== 1'b1) begin
      errors++;
      $display("FAIL down_wrap: count=%0d wrap=%b expected 9/1", count, wrap);
    end
    step();
    checks++;
    if (count !== 27'd9 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL down_wrap_len: count=%0d wrap=%b expected 9/0", count, wrap);
    end
    // dir toggles between ticks; only the value present on the tick cycle matters
    dir = 1'b0;
    step();
    dir = 1'b1;
    step();
    dir = 1'b0;
    checks++;
    if (count !== 27'd9) begin
      errors++;
      $display("FAIL dir_between_ticks: count=%0d expected 9", count);
    end
    step();
    checks++;
    if (count !== 27'd0 || wrap !== 1'b1) begin
      errors++;
      $display("FAIL up_wrap: count=%0d wrap=%b expected 0/1", count, wrap);
    end
    step();
    checks++;
    if (count !== 27'd0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL up_wrap_len: count=%0d wrap=%b expected 0/0", count, wrap);
    end
  endtask

  task automatic test_pause();
    logic bad;
    bad = 1'b0;
    do_clear();
    dir = 1'b0;
    pulse_ss();
    step();
    step();
    pulse_ss();
    checks++;
    if (state !== 2'b10 || running !== 1'b0) begin
      errors++;
      $display("FAIL pause_enter: state=%b running=%b expected 10/0", state, running);
    end
    repeat (20) begin
      step();
      if (count !== 27'd0 || state !== 2'b10) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL pause_frozen: count=%0d state=%b expected 0/10", count, state);
    end
    pulse_ss();
    checks++;
    if (state !== 2'b01 || count !== 27'd0) begin
      errors++;
      $display("FAIL resume: state=%b count=%0d expected 01/0", state, count);
    end
    step();
    checks++;
    if (count !== 27'd0) begin
      errors++;
      $display("FAIL resume_plus1: count=%0d expected 0", count);
    end
    step();
    checks++;
    if (count !== 27'd1) begin
      errors++;
      $display("FAIL resume_plus2: count=%0d expected 1", count);
    end
  endtask

  task automatic test_clear_priority();
    do_clear();
    dir = 1'b0;
    pulse_ss();
    repeat (20) step();
    checks++;
    if (count !== 27'd5) begin
      errors++;
      $display("FAIL clr_setup: count=%0d expected 5", count);
    end
    repeat (3) step();
    clear = 1'b1;
    start_stop = 1'b1;
    lap = 1'b1;
    step();
    clear = 1'b0;
    start_stop = 1'b0;
    lap = 1'b0;
    checks++;
    if (state !== 2'b00 || count !== 27'd0 || wrap !== 1'b0 || hold !== 1'b0) begin
      errors++;
      $display("FAIL clr_prio: state=%b count=%0d wrap=%b hold=%b expected 00/0/0/0",
               state, count, wrap, hold);
    end
    step();
    checks++;
    if (state !== 2'b00 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL clr_after: state=%b wrap=%b expected 00/0", state, wrap);
    end
    clear = 1'b1;
    start_stop = 1'b1;
    step();
    clear = 1'b0;
    start_stop = 1'b0;
    checks++;
    if (state !== 2'b00) begin
      errors++;
      $display("FAIL clr_idle_ss: state=%b expected 00", state);
    end
  endtask

  task automatic test_lap();
    logic [26:0] exp_num;
    logic        exp_hold;
    do_clear();
    dir = 1'b0;
    pulse_ss();
    repeat (12) step();
    checks++;
    if (count !== 27'd3) begin
      errors++;
      $display("FAIL lap_setup: count=%0d expected 3", count);
    end
    lap = 1'b1;
    step();
    lap = 1'b0;
`ifdef DIGIT8_LAP_HOLD_EN
    exp_hold = 1'b1;
`else
    exp_hold = 1'b0;
`endif
    checks++;
    if (hold !== exp_hold || num !== 27'd3) begin
      errors++;
      $display("FAIL lap_capture: hold=%b num=%0d expected %b/3", hold, num, exp_hold);
    end
    repeat (11) step();
    exp_num = exp_hold ? 27'd3 : 27'd6;
    checks++;
    if (count !== 27'd6 || num !== exp_num || hold !== exp_hold) begin
      errors++;
      $display("FAIL lap_held: count=%0d num=%0d hold=%b expected 6/%0d/%b",
               count, num, hold, exp_num, exp_hold);
    end
    lap = 1'b1;
    step();
    lap = 1'b0;
    checks++;
    if (hold !== 1'b0 || num !== 27'd6) begin
      errors++;
      $display("FAIL lap_release: hold=%b num=%0d expected 0/6", hold, num);
    end
    do_clear();
    lap = 1'b1;
    step();
    lap = 1'b0;
    checks++;
    if (hold !== 1'b0 || state !== 2'b00) begin
      errors++;
      $display("FAIL lap_idle: hold=%b state=%b expected 0/00", hold, state);
    end
  endtask

  task automatic test_reset_mid_run();
    do_clear();
    dir = 1'b0;
    pulse_ss();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (state !== 2'b00 || count !== 27'd0 || wrap !== 1'b0 || running !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: state=%b count=%0d wrap=%b running=%b expected 00/0/0/0",
               state, count, wrap, running);
    end
    pulse_ss();
    repeat (3) step();
    checks++;
    if (count !== 27'd0) begin
      errors++;
      $display("FAIL rst_restart_pre: count=%0d expected 0", count);
    end
    step();
    checks++;
    if (count !== 27'd1) begin
      errors++;
      $display("FAIL rst_restart: count=%0d expected 1", count);
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap();
    test_pause();
    test_clear_priority();
    test_lap();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
